// File: rtl/relu_quant_maxpool_pkg.sv
// Shared definitions for the ReLU / quantize / 2x2 max-pool layer stage.
// Holds accumulator and pixel widths, the pixel ceiling, lane typedefs and
// an unsigned max helper reused by later layer stages.
package relu_quant_maxpool_pkg;

   localparam int unsigned ACC_WIDTH = 32;
   localparam int unsigned PIX_WIDTH = 8;
   localparam int unsigned PIX_MAX   = 255;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;
   typedef logic        [PIX_WIDTH-1:0] pix_t;

   // Unsigned value-only max; tie order is irrelevant.
   function automatic pix_t pix_max2(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/relu_quant_maxpool_if.sv
// Streaming bus between the convolution stage and the pooling stage.
// valid_in / pixel_vector_in : upstream beat (NUM_TREES signed accumulators)
// valid_out / pixel_vector_out: pooled pulse (NUM_TREES unsigned pixels)
interface relu_quant_maxpool_if
   import relu_quant_maxpool_pkg::*;
#(
   parameter int unsigned NUM_TREES = 2
) ();

   logic                           valid_in;
   logic [ACC_WIDTH*NUM_TREES-1:0] pixel_vector_in;
   logic                           valid_out;
   logic [PIX_WIDTH*NUM_TREES-1:0] pixel_vector_out;

   modport master (
      output valid_in,
      output pixel_vector_in,
      input  valid_out,
      input  pixel_vector_out
   );

   modport slave (
      input  valid_in,
      input  pixel_vector_in,
      output valid_out,
      output pixel_vector_out
   );

endinterface

// File: rtl/relu_quant_maxpool_relu_quant.sv
// Per-lane ReLU plus arithmetic down-shift and saturation to one pixel.
// acc : signed accumulator in
// q_c : combinational unsigned pixel out
module relu_quant
   import relu_quant_maxpool_pkg::*;
#(
   parameter int unsigned SHIFT = 4
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   output logic        [PIX_WIDTH-1:0] q_c
);

   logic signed [ACC_WIDTH-1:0] shifted;

   // Negative clamps to zero; positive is scaled then saturated.
   always_comb begin
      shifted = acc >>> SHIFT;
      q_c     = '0;
      if (acc[ACC_WIDTH-1]) begin
         q_c = '0;
      end else if (shifted > $signed(ACC_WIDTH'(PIX_MAX))) begin
         q_c = PIX_WIDTH'(PIX_MAX);
      end else begin
         q_c = shifted[PIX_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/relu_quant_maxpool.sv
// ReLU + quantize each lane, then 2x2 max-pool over a raster stream.
// clock, reset : single clock, synchronous active-high reset
// bus (slave)  : valid_in/pixel_vector_in in, valid_out/pixel_vector_out out
// Output pulse appears two cycles after the beat closing a 2x2 window.
module relu_quant_maxpool
   import relu_quant_maxpool_pkg::*;
#(
   parameter int unsigned NUM_TREES = 2,
   parameter int unsigned ROW_WIDTH = 4,
   parameter int unsigned SHIFT     = 4
) (
   input  logic          clock,
   input  logic          reset,
   relu_quant_maxpool_if.slave bus
);

   localparam int unsigned COL_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
   localparam int unsigned HALF  = ROW_WIDTH / 2;
   localparam int unsigned LB_AW = (HALF > 1) ? $clog2(HALF) : 1;

   typedef logic [NUM_TREES-1:0][PIX_WIDTH-1:0] lanes_t;

   lanes_t             q_c;
   logic [COL_W-1:0]   col;
   logic               row_odd;
   logic               s1_valid;
   lanes_t             s1_q;
   logic [COL_W-1:0]   s1_col;
   logic               s1_row_odd;
   lanes_t             hold;
   lanes_t             linebuf [HALF];
   lanes_t             h_c;
   lanes_t             pool_c;
   logic [LB_AW-1:0]   lb_idx_c;
   logic               valid_out_r;
   lanes_t             pix_out_r;

   // One quantizer per lane.
   for (genvar t = 0; t < NUM_TREES; t++) begin : g_lane
      relu_quant #(.SHIFT(SHIFT)) u_relu_quant (
         .acc (bus.pixel_vector_in[ACC_WIDTH*t +: ACC_WIDTH]),
         .q_c (q_c[t])
      );
   end

   // Stage 1: capture quantized beat with its column/row position.
   always_ff @(posedge clock) begin
      if (reset) begin
         col        <= '0;
         row_odd    <= 1'b0;
         s1_valid   <= 1'b0;
         s1_q       <= '0;
         s1_col     <= '0;
         s1_row_odd <= 1'b0;
      end else begin
         s1_valid <= bus.valid_in;
         if (bus.valid_in) begin
            s1_q       <= q_c;
            s1_col     <= col;
            s1_row_odd <= row_odd;
            if (col == COL_W'(ROW_WIDTH - 1)) begin
               col     <= '0;
               row_odd <= ~row_odd;
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

   // Horizontal pair max and vertical max against the stored even row.
   always_comb begin
      lb_idx_c = LB_AW'(s1_col >> 1);
      h_c      = '0;
      pool_c   = '0;
      for (int t = 0; t < int'(NUM_TREES); t++) begin
         h_c[t]    = pix_max2(hold[t], s1_q[t]);
         pool_c[t] = pix_max2(linebuf[lb_idx_c][t], h_c[t]);
      end
   end

   // Stage 2: horizontal hold and pooled output register.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold        <= '0;
         valid_out_r <= 1'b0;
         pix_out_r   <= '0;
      end else begin
         valid_out_r <= 1'b0;
         if (s1_valid) begin
            if (!s1_col[0]) begin
               hold <= s1_q;
            end else if (s1_row_odd) begin
               valid_out_r <= 1'b1;
               pix_out_r   <= pool_c;
            end
         end
      end
   end

   // Line buffer: every entry is written on an even row before it is read.
   always_ff @(posedge clock) begin
      if (!reset && s1_valid && s1_col[0] && !s1_row_odd) begin
         linebuf[lb_idx_c] <= h_c;
      end
   end

   assign bus.valid_out        = valid_out_r;
   assign bus.pixel_vector_out = pix_out_r;

endmodule

// File: tb/tb_relu_quant_maxpool.sv
// Directed bench for relu_quant_maxpool (NUM_TREES=2, ROW_WIDTH=4, SHIFT=4).
module tb_relu_quant_maxpool;
   import relu_quant_maxpool_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   relu_quant_maxpool_if #(.NUM_TREES(2)) bus ();

   relu_quant_maxpool #(.NUM_TREES(2), .ROW_WIDTH(4), .SHIFT(4)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   logic signed [31:0] uq_in;
   logic        [7:0]  uq_out;
   relu_quant #(.SHIFT(4)) u_q (.acc(uq_in), .q_c(uq_out));

   int total = 0;
   int bad   = 0;

   int         pul_cyc [$];
   logic [7:0] pul_l0  [$];
   logic [7:0] pul_l1  [$];
   int         exp_cyc [$];
   logic [7:0] exp_l0  [$];
   logic [7:0] exp_l1  [$];
   int         beat_cyc[$];

   always @(negedge clk) begin
      if (bus.valid_out === 1'b1) begin
         pul_cyc.push_back(cyc);
         pul_l0.push_back(bus.pixel_vector_out[7:0]);
         pul_l1.push_back(bus.pixel_vector_out[15:8]);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [31:0] a0, input logic signed [31:0] a1, input int gap);
      bus.pixel_vector_in = {a1, a0};
      bus.valid_in        = 1'b1;
      beat_cyc.push_back(cyc);
      tick();
      bus.valid_in = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic clear_q();
      pul_cyc.delete(); pul_l0.delete(); pul_l1.delete();
      exp_cyc.delete(); exp_l0.delete(); exp_l1.delete();
      beat_cyc.delete();
   endtask

   // Expect pulses after the 6th and 8th beat of the row pair starting at b0.
   task automatic expect_pair(input int b0, input logic [7:0] e0a, input logic [7:0] e0b,
                              input logic [7:0] e1a, input logic [7:0] e1b);
      exp_cyc.push_back(beat_cyc[b0+5] + 2); exp_l0.push_back(e0a); exp_l1.push_back(e1a);
      exp_cyc.push_back(beat_cyc[b0+7] + 2); exp_l0.push_back(e0b); exp_l1.push_back(e1b);
   endtask

   // Rows 16..64 / 80..128 on lane 0 (+off), lane 1 doubled.
   task automatic send_frame(input int off, input int gap);
      int b0;
      int v;
      b0 = beat_cyc.size();
      for (int i = 0; i < 8; i++) begin
         v = 16 * (i + 1) + off;
         send(32'(v), 32'(2 * v), gap);
      end
      expect_pair(b0, 8'(6 + off / 16), 8'(8 + off / 16),
                  8'(12 + off / 8), 8'(16 + off / 8));
   endtask

   task automatic verify(input string tag);
      int n;
      repeat (4) tick();
      check({tag, "_count"}, 32'(pul_cyc.size()), 32'(exp_cyc.size()));
      n = (pul_cyc.size() < exp_cyc.size()) ? pul_cyc.size() : exp_cyc.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_l0_%0d", tag, i), 32'(pul_l0[i]), 32'(exp_l0[i]));
         check($sformatf("%s_l1_%0d", tag, i), 32'(pul_l1[i]), 32'(exp_l1[i]));
         check($sformatf("%s_cyc_%0d", tag, i), 32'(pul_cyc[i]), 32'(exp_cyc[i]));
      end
   endtask

   logic signed [31:0] qa [6];
   logic        [7:0]  qe [6];
   int                 b0;

   initial begin
      rst                 = 1'b1;
      bus.valid_in        = 1'b0;
      bus.pixel_vector_in = '0;
      uq_in               = '0;
      repeat (3) tick();
      check("rst_valid_out", 32'(bus.valid_out), 32'd0);
      check("rst_pix_out", 32'(bus.pixel_vector_out), 32'd0);
      rst = 1'b0;
      tick();

      // Quantizer unit vectors.
      qa = '{-32'sd5, 32'sd588, 32'sd4095, 32'sd4096, 32'sd100000, 32'sd15};
      qe = '{8'd0, 8'd36, 8'd255, 8'd255, 8'd255, 8'd0};
      for (int i = 0; i < 6; i++) begin
         uq_in = qa[i];
         #1;
         check($sformatf("quant_%0d", i), 32'(uq_out), 32'(qe[i]));
      end

      // Continuous frame.
      clear_q();
      send_frame(0, 0);
      verify("cont");
      check("hold_valid", 32'(bus.valid_out), 32'd0);
      check("hold_pix", 32'(bus.pixel_vector_out), 32'h1008);

      // Gaps of 3 idle cycles between beats.
      clear_q();
      send_frame(0, 3);
      verify("gap");

      // All-negative input pools to zero.
      clear_q();
      for (int i = 0; i < 8; i++) send(-32'sd100, -32'sd100, 0);
      expect_pair(0, 8'd0, 8'd0, 8'd0, 8'd0);
      verify("neg");

      // Quantization through the pool: uniform halves, lane 1 saturated.
      clear_q();
      qa = '{-32'sd5, 32'sd588, 32'sd4095, 32'sd4096, 32'sd100000, -32'sd5};
      for (int p = 0; p < 3; p++) begin
         b0 = beat_cyc.size();
         for (int i = 0; i < 8; i++) send(qa[2*p + (i % 4) / 2], 32'h7fffffff, 0);
         expect_pair(b0, qe[2*p], qe[2*p+1], 8'd255, 8'd255);
      end
      qe[5] = 8'd0;
      verify("qpool");

      // Reset after row 0 and 3 beats of row 1, valid_in held high in reset.
      for (int i = 0; i < 7; i++) send(32'sd4000, 32'sd4000, 0);
      rst                 = 1'b1;
      bus.valid_in        = 1'b1;
      bus.pixel_vector_in = {32'sd4000, 32'sd4000};
      tick();
      check("midrst_valid_out", 32'(bus.valid_out), 32'd0);
      check("midrst_pix_out", 32'(bus.pixel_vector_out), 32'd0);
      tick();
      rst          = 1'b0;
      bus.valid_in = 1'b0;
      repeat (2) tick();
      clear_q();
      send_frame(0, 0);
      verify("rst");

      // Three row pairs back to back.
      clear_q();
      send_frame(0, 0);
      send_frame(16, 0);
      send_frame(32, 0);
      verify("wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/relu_quant_maxpool.md
RELU_QUANT_MAXPOOL -- requirements
Module: relu_quant_maxpool

Interface
REQ-001 Parameter NUM_TREES, default 2: number of kernel lanes carried side by side in the input vector.
REQ-002 Parameter ROW_WIDTH, default 4: convolution outputs per image row; SHALL be even and at least 2.
REQ-003 Parameter SHIFT, default 4: arithmetic right-shift applied before saturation.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 valid_in  input  1  a new input vector is present this cycle.
REQ-007 pixel_vector_in  input  32*NUM_TREES  signed 32-bit accumulations from the upstream convolution stage; lane t is bits [32t+31:32t].
REQ-008 valid_out  output  1  one-cycle pulse marking a pooled output.
REQ-009 pixel_vector_out  output  8*NUM_TREES  unsigned 8-bit pooled pixels; lane t is bits [8t+7:8t].

Function
REQ-010 Each lane SHALL be quantized as follows: if x<0 then q=0; else y=x>>>SHIFT, and q=255 if y>255, otherwise q=y[7:0].
REQ-011 Stage 1 SHALL register q for all lanes, plus valid_in, the column index and the row parity, on every cycle with valid_in=1.
REQ-012 The column counter SHALL advance only on valid_in=1, run 0..ROW_WIDTH-1, and wrap to 0 after ROW_WIDTH-1; each wrap SHALL toggle the row parity.
REQ-013 On an even column, the stage SHALL hold q per lane in a horizontal register.
REQ-014 On an odd column, the stage SHALL form h=max(hold,q) per lane.
REQ-015 On an even row at an odd column, h SHALL be written to the line buffer at entry col>>1.
REQ-016 On an odd row at an odd column, the stage SHALL compute max(linebuf[col>>1], h) per lane.
REQ-017 That result SHALL be registered to pixel_vector_out, with valid_out=1 exactly 2 cycles after the input beat that completes the 2x2 window.
REQ-018 valid_in=0 SHALL leave the counters, parity, hold register and line buffer unchanged; gaps of any length between beats SHALL NOT alter results.
REQ-019 Each row pair SHALL produce exactly ROW_WIDTH/2 valid_out pulses; even rows SHALL produce none.
REQ-020 pixel_vector_out SHALL hold its last value while valid_out=0.
REQ-021 The line buffer SHALL hold ROW_WIDTH/2 entries of 8*NUM_TREES bits.
REQ-022 The line buffer SHALL be written and read in the same cycle only at distinct phases (even row writes, odd row reads), so no read-during-write hazard exists.
REQ-023 Comparisons SHALL be unsigned 8-bit; ties are irrelevant because max is value-only.
REQ-024 No backpressure: the block SHALL accept one beat every cycle indefinitely.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL clear the column counter and row parity (even), stage-1 valid, valid_out, pixel_vector_out and the hold registers to 0.
REQ-026 Line buffer contents SHALL NOT be reset, since every entry is written before it is read.
REQ-027 Reset mid-row or mid-row-pair SHALL discard the partial window; the first beat after reset SHALL be treated as row 0, column 0.
REQ-028 valid_in asserted during reset SHALL be ignored.

Structure
REQ-029 A shared package/header SHALL hold ACC_WIDTH=32, PIX_WIDTH=8 and PIX_MAX=255, for reuse by other layer stages.
REQ-030 Per-lane quantization SHALL be the sub-module relu_quant (combinational, ACC_WIDTH in, PIX_WIDTH out, SHIFT parameter), instantiated NUM_TREES times.
REQ-031 The counters, line buffer and pooling logic SHALL reside in relu_quant_maxpool.

Verification (NUM_TREES=2, ROW_WIDTH=4, SHIFT=4)
REQ-032 Quantize lane 0 with inputs -5, 588, 4095, 4096 and 100000 -> 0, 36, 255, 255 and 255 respectively.
REQ-033 Continuous pooling, lane 0 rows 16,32,48,64 / 80,96,112,128 and lane 1 set to 2x lane 0:
- lane 0 SHALL yield 6 then 8;
- lane 1 SHALL yield 12 then 16;
- valid_out SHALL pulse 2 cycles after beats 6 and 8 of the frame, and at no other time.
REQ-034 The same data as REQ-033 with valid_in=0 for 3 cycles between every beat -> identical output values and exactly 2 pulses.
REQ-035 All inputs set to -100 for two rows -> 2 pulses, each with pixel_vector_out=0.
REQ-036 Reset asserted after 3 beats of row 1, then the full REQ-033 frame -> outputs 6 and 8 only, with no pulse derived from the pre-reset data.
REQ-037 Three row pairs back to back, with row pair k's values offset by +16k -> pulses 6, 8, 7, 9, 8, 10 in order, exercising counter and parity wrap.
